// File: rtl/dmem_responder_pkg.sv
// y86_mem_pkg: shared definitions for the Y86 data-memory responder.
//   - dmr_state_t   : responder FSM states (IDLE, ACCESS, DRAIN, DONE)
//   - QWORD_BYTES   : bytes per Y86 quadword transfer
//   - DEFAULT_MEM_AW: default byte-address width of the backing RAM
package y86_mem_pkg;

  localparam int unsigned QWORD_BYTES    = 8;
  localparam int unsigned DEFAULT_MEM_AW = 12;

  typedef enum logic [1:0] {
    DMR_IDLE   = 2'd0,
    DMR_ACCESS = 2'd1,
    DMR_DRAIN  = 2'd2,
    DMR_DONE   = 2'd3
  } dmr_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: quadword data-memory handshake between the microcoded
// control unit / datapath (master) and the memory responder (slave).
//   dmem_read/dmem_write : request strobes, held until DMemReady
//   dmem_addr            : quadword byte address (valE)
//   dmem_wdata           : write data (valA)
//   dmem_rdata           : read result (valM)
//   DMemReady            : one-cycle completion pulse
//   dmem_error           : request rejected, valid with DMemReady
interface dmem_responder_if;

  logic        dmem_read;
  logic        dmem_write;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [63:0] dmem_rdata;
  logic        DMemReady;
  logic        dmem_error;

  modport master (
    output dmem_read, dmem_write, dmem_addr, dmem_wdata,
    input  dmem_rdata, DMemReady, dmem_error
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_addr, dmem_wdata,
    output dmem_rdata, DMemReady, dmem_error
  );

endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: performs one 64-bit little-endian quadword read or write
// as eight sequential byte accesses on a byte-wide synchronous RAM
// (1-cycle read latency), then pulses DMemReady for one cycle.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bus (slave) : quadword request/response handshake
//   mem_addr    : RAM byte address
//   mem_wdata   : RAM write byte
//   mem_we      : RAM write enable
//   mem_rdata   : RAM read byte, valid one cycle after mem_addr
// All outputs are registered.
module dmem_responder
  import y86_mem_pkg::*;
#(
  parameter int unsigned MEM_AW    = DEFAULT_MEM_AW,
  parameter int unsigned MEM_BYTES = 2 ** DEFAULT_MEM_AW
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  localparam logic [64:0] LAST_BYTE = 65'(MEM_BYTES) - 65'd1;
  localparam logic [64:0] QW_SPAN   = 65'(QWORD_BYTES - 1);
  localparam logic [2:0]  LAST_IDX  = 3'(QWORD_BYTES - 1);

  dmr_state_t  state;
  logic [2:0]  idx;
  logic        is_write;
  // Byte 0 goes straight to mem_wdata on acceptance; only bytes 1..7 are kept.
  logic [55:0] wdata_hi;

  logic        req_bad;
  logic [2:0]  idx_prev;

  always_comb begin
    // 65-bit sum so addresses near 2**64 cannot wrap past the range check.
    req_bad  = (bus.dmem_read && bus.dmem_write) ||
               (({1'b0, bus.dmem_addr} + QW_SPAN) > LAST_BYTE);
    idx_prev = idx - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= DMR_IDLE;
      idx            <= '0;
      is_write       <= 1'b0;
      wdata_hi       <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_we         <= 1'b0;
      bus.dmem_rdata <= '0;
      bus.DMemReady  <= 1'b0;
      bus.dmem_error <= 1'b0;
    end else begin
      case (state)
        DMR_IDLE: begin
          if (bus.dmem_read || bus.dmem_write) begin
            if (req_bad) begin
              state          <= DMR_DONE;
              bus.DMemReady  <= 1'b1;
              bus.dmem_error <= 1'b1;
            end else begin
              state    <= DMR_ACCESS;
              idx      <= '0;
              is_write <= bus.dmem_write;
              wdata_hi <= bus.dmem_wdata[63:8];
              mem_addr <= bus.dmem_addr[MEM_AW-1:0];
              mem_we   <= bus.dmem_write;
              if (bus.dmem_write) begin
                mem_wdata <= bus.dmem_wdata[7:0];
              end
            end
          end
        end

        DMR_ACCESS: begin
          // RAM returns the byte addressed in the previous cycle.
          if (!is_write && idx != 3'd0) begin
            bus.dmem_rdata[{idx_prev, 3'b000} +: 8] <= mem_rdata;
          end
          if (idx == LAST_IDX) begin
            mem_we <= 1'b0;
            if (is_write) begin
              state         <= DMR_DONE;
              bus.DMemReady <= 1'b1;
            end else begin
              state <= DMR_DRAIN;
            end
          end else begin
            idx      <= idx + 3'd1;
            mem_addr <= mem_addr + MEM_AW'(1);
            if (is_write) begin
              // wdata_hi byte k holds quadword byte k+1.
              mem_wdata <= wdata_hi[{idx, 3'b000} +: 8];
            end
          end
        end

        DMR_DRAIN: begin
          bus.dmem_rdata[63:56] <= mem_rdata;
          state                 <= DMR_DONE;
          bus.DMemReady         <= 1'b1;
        end

        DMR_DONE: begin
          bus.DMemReady  <= 1'b0;
          bus.dmem_error <= 1'b0;
          state          <= DMR_IDLE;
        end

        default: state <= DMR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder with a byte RAM
// (1-cycle read latency, write-first) and a cycle-indexed expectation model.
module tb_dmem_responder;
  import y86_mem_pkg::*;

  localparam int MEM_AW    = 12;
  localparam int MEM_BYTES = 4096;
  localparam int NCYC      = 2048;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus ();
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_we;

  dmem_responder #(.MEM_AW(MEM_AW), .MEM_BYTES(MEM_BYTES)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  // dmem_byte_ram: behavioural byte RAM
  logic [7:0] ram [0:MEM_BYTES-1];
  logic       ram_init;

  function automatic logic [7:0] init_byte(int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < MEM_BYTES; i++) ram[i] <= init_byte(i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      mem_rdata     <= mem_wdata;
    end else begin
      mem_rdata <= ram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs per cycle, filled from the transaction rules.
  bit          exp_rdy [NCYC];
  bit          exp_err [NCYC];
  bit          exp_we  [NCYC];
  bit          chk_ma  [NCYC];
  logic [11:0] exp_ma  [NCYC];
  logic [7:0]  exp_wb  [NCYC];
  logic [63:0] exp_rd  [NCYC];
  logic [7:0]  model_mem [MEM_BYTES];
  logic [63:0] model_rdata;

  // n: cycle in which the request is first visible to the idle responder.
  // abort_at: cycle whose outputs already show a reset (0 = no reset).
  function automatic void model_req(int n, bit rd, bit wr, logic [63:0] addr,
                                    logic [63:0] wd, int abort_at);
    int base;
    int c;
    int limit;
    limit = (abort_at == 0) ? NCYC : abort_at;
    if ((rd && wr) || (addr > 64'(MEM_BYTES - 8))) begin
      exp_rdy[n+1] = 1'b1;
      exp_err[n+1] = 1'b1;
      exp_rd[n+1]  = model_rdata;
      return;
    end
    base = {20'd0, addr[11:0]};
    for (int i = 0; i < 8; i++) begin
      c = n + 1 + i;
      if (c >= limit) break;
      chk_ma[c] = 1'b1;
      exp_ma[c] = 12'(base + i);
      if (wr) begin
        exp_we[c]           = 1'b1;
        exp_wb[c]           = wd[8*i +: 8];
        model_mem[base + i] = wd[8*i +: 8];
      end
    end
    if (abort_at != 0) begin
      model_rdata = '0;
      return;
    end
    if (wr) begin
      exp_rdy[n+9] = 1'b1;
      exp_rd[n+9]  = model_rdata;
    end else begin
      for (int i = 0; i < 8; i++) model_rdata[8*i +: 8] = model_mem[base + i];
      exp_rdy[n+10] = 1'b1;
      exp_rd[n+10]  = model_rdata;
    end
  endfunction

  bit chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on && !reset && cyc < NCYC) begin
      check("DMemReady", 64'(bus.DMemReady), 64'(exp_rdy[cyc]));
      check("mem_we", 64'(mem_we), 64'(exp_we[cyc]));
      if (chk_ma[cyc]) check("mem_addr", 64'(mem_addr), 64'(exp_ma[cyc]));
      if (exp_we[cyc]) check("mem_wdata", 64'(mem_wdata), 64'(exp_wb[cyc]));
      if (exp_rdy[cyc]) begin
        check("dmem_error", 64'(bus.dmem_error), 64'(exp_err[cyc]));
        check("dmem_rdata", bus.dmem_rdata, exp_rd[cyc]);
      end
    end
  end

  // Called at posedge+2; offs=1 when the DUT is in DONE this cycle.
  task automatic do_req(bit rd, bit wr, logic [63:0] a, logic [63:0] wd,
                        int offs, bit hold, output int rc);
    model_req(cyc + offs, rd, wr, a, wd, 0);
    bus.dmem_read  = rd;
    bus.dmem_write = wr;
    bus.dmem_addr  = a;
    bus.dmem_wdata = wd;
    rc = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #2;
      if (bus.DMemReady) begin
        rc = cyc;
        break;
      end
    end
    compared++;
    if (rc < 0) begin
      mismatched++;
      $display("FAIL wait_ready: no DMemReady within 40 cycles, addr %h", a);
    end
    if (!hold) begin
      bus.dmem_read  = 1'b0;
      bus.dmem_write = 1'b0;
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int n0;
    int rc;
    int rc2;
    int bad_cnt;
    int first_bad;

    ram_init       = 1'b1;
    bus.dmem_read  = 1'b0;
    bus.dmem_write = 1'b0;
    bus.dmem_addr  = '0;
    bus.dmem_wdata = '0;
    for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = init_byte(i);
    model_rdata = '0;

    idle(3);
    ram_init = 1'b0;
    check("rst_rdata", bus.dmem_rdata, 64'h0);
    check("rst_ready", 64'(bus.DMemReady), 64'h0);
    check("rst_error", 64'(bus.dmem_error), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'h0);
    check("rst_mem_we", 64'(mem_we), 64'h0);
    reset  = 1'b0;
    chk_on = 1'b1;
    idle(1);

    // Quadword write, then read it back.
    n0 = cyc;
    do_req(1'b0, 1'b1, 64'h100, 64'h0807060504030201, 0, 1'b0, rc);
    check("write_latency", 64'(rc - n0), 64'd9);
    idle(2);
    n0 = cyc;
    do_req(1'b1, 1'b0, 64'h100, 64'h0, 0, 1'b0, rc);
    check("read_latency", 64'(rc - n0), 64'd10);
    check("read_0x100", bus.dmem_rdata, 64'h0807060504030201);
    idle(2);

    // Range error: last byte would be 0x1000.
    n0 = cyc;
    do_req(1'b1, 1'b0, 64'hFF9, 64'h0, 0, 1'b0, rc);
    check("range_err_latency", 64'(rc - n0), 64'd1);
    check("range_err_flag", 64'(bus.dmem_error), 64'd1);
    check("range_err_rdata", bus.dmem_rdata, 64'h0807060504030201);
    check("range_err_mem_addr", 64'(mem_addr), 64'h107);
    idle(2);

    // Read and write both asserted.
    n0 = cyc;
    do_req(1'b1, 1'b1, 64'h0, 64'hDEADBEEFCAFEF00D, 0, 1'b0, rc);
    check("rw_err_latency", 64'(rc - n0), 64'd1);
    check("rw_err_flag", 64'(bus.dmem_error), 64'd1);
    idle(2);

    // Highest legal quadword address.
    do_req(1'b1, 1'b0, 64'hFF8, 64'h0, 0, 1'b0, rc);
    check("read_0xff8", bus.dmem_rdata, 64'hA5A4A7A6A1A0A3A2);
    idle(1);

    // Address whose +7 would wrap a 64-bit sum.
    n0 = cyc;
    do_req(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 0, 1'b0, rc);
    check("wrap_err_latency", 64'(rc - n0), 64'd1);
    idle(2);

    // Back-to-back reads, request held and address switched on the ready cycle.
    do_req(1'b1, 1'b0, 64'h100, 64'h0, 0, 1'b1, rc);
    do_req(1'b1, 1'b0, 64'h108, 64'h0, 1, 1'b0, rc2);
    check("b2b_spacing", 64'(rc2 - rc), 64'd11);
    check("read_0x108", bus.dmem_rdata, 64'h5554575651505352);
    idle(2);

    // Reset while writing: bytes 0..2 land, then abort.
    n0 = cyc;
    model_req(n0, 1'b0, 1'b1, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF, n0 + 4);
    bus.dmem_write = 1'b1;
    bus.dmem_addr  = 64'h200;
    bus.dmem_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    idle(3);
    reset          = 1'b1;
    bus.dmem_write = 1'b0;
    idle(1);
    check("abort_rdata", bus.dmem_rdata, 64'h0);
    check("abort_ready", 64'(bus.DMemReady), 64'h0);
    check("abort_mem_addr", 64'(mem_addr), 64'h0);
    check("abort_mem_wdata", 64'(mem_wdata), 64'h0);
    check("abort_mem_we", 64'(mem_we), 64'h0);
    reset = 1'b0;
    idle(12);

    do_req(1'b1, 1'b0, 64'h200, 64'h0, 0, 1'b0, rc);
    check("read_0x200", bus.dmem_rdata, 64'h5D5C5F5E59FFFFFF);
    idle(3);

    check("ram_0x100", 64'(ram[12'h100]), 64'h01);
    check("ram_0x107", 64'(ram[12'h107]), 64'h08);
    check("ram_0x202", 64'(ram[12'h202]), 64'hFF);
    check("ram_0x203", 64'(ram[12'h203]), 64'h59);
    check("ram_0x000", 64'(ram[12'h000]), 64'h5A);

    bad_cnt   = 0;
    first_bad = -1;
    for (int i = 0; i < MEM_BYTES; i++) begin
      if (ram[i] !== model_mem[i]) begin
        bad_cnt++;
        if (first_bad < 0) first_bad = i;
      end
    end
    compared++;
    if (bad_cnt != 0) begin
      mismatched++;
      $display("FAIL ram_image: %0d bytes differ, first at %h got %h expected %h",
               bad_cnt, first_bad, ram[first_bad], model_mem[first_bad]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
